// File: rtl/stage2_msg_pkg.sv
// Shared definitions for the stage-2 message sequence tracker.
// Provides the status field type and the status encodings that the tracker
// presents on out_status.
package stage2_msg_pkg;

    typedef logic [1:0] status_t;

    localparam status_t ST_IN_ORDER = 2'd0;
    localparam status_t ST_GAP      = 2'd1;
    localparam status_t ST_STALE    = 2'd2;
    localparam status_t ST_SYNC     = 2'd3;

endpackage

// File: rtl/stage2_seq_compare.sv
// Combinational classifier for one message against one channel's state.
// Ports:
//   synced        - channel has seen a first message since reset/resync
//   expected      - next sequence number the channel expects
//   seq           - received sequence number
//   status        - SYNC / IN_ORDER / GAP / STALE
//   gap_len       - number of missing messages (GAP only, else 0)
//   next_expected - seq + 1, wrapping
//   update_en     - expected should be replaced by next_expected
module stage2_seq_compare
    import stage2_msg_pkg::*;
#(
    parameter int unsigned SEQ_W = 32
) (
    input  logic             synced,
    input  logic [SEQ_W-1:0] expected,
    input  logic [SEQ_W-1:0] seq,
    output status_t          status,
    output logic [SEQ_W-1:0] gap_len,
    output logic [SEQ_W-1:0] next_expected,
    output logic             update_en
);

    logic [SEQ_W-1:0] diff;

    // Modular distance; the top half of the range is read as "behind".
    assign diff          = seq - expected;
    assign next_expected = seq + SEQ_W'(1);

    always_comb begin
        status    = ST_STALE;
        gap_len   = '0;
        update_en = 1'b0;
        if (!synced) begin
            status    = ST_SYNC;
            update_en = 1'b1;
        end else if (diff == '0) begin
            status    = ST_IN_ORDER;
            update_en = 1'b1;
        end else if (!diff[SEQ_W-1]) begin
            status    = ST_GAP;
            gap_len   = diff;
            update_en = 1'b1;
        end
    end

endmodule

// File: rtl/stage2_message_seq_tracker.sv
// Per-channel sequence-number tracker. Classifies each accepted header as
// SYNC, IN_ORDER, GAP or STALE and presents it one cycle later through a
// single registered output stage.
// Ports:
//   clk, rst                        - clock, async active-high reset
//   in_valid/in_ready               - header handshake
//   in_channel, in_seq              - header fields (out-of-range channel -> 0)
//   resync_valid, resync_channel    - force a channel back to unsynced
//   out_valid/out_ready             - classified message handshake
//   out_channel, out_seq            - echoed header
//   out_status, out_gap_len         - classification result
//   gap_events                      - saturating count of GAP results
module stage2_message_seq_tracker
    import stage2_msg_pkg::*;
#(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    parameter int unsigned SEQ_W     = 32,
    parameter int unsigned GAP_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CH_W-1:0]      in_channel,
    input  logic [SEQ_W-1:0]     in_seq,
    input  logic                 resync_valid,
    input  logic [CH_W-1:0]      resync_channel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH_W-1:0]      out_channel,
    output logic [SEQ_W-1:0]     out_seq,
    output status_t              out_status,
    output logic [SEQ_W-1:0]     out_gap_len,
    output logic [GAP_CNT_W-1:0] gap_events
);

    localparam logic [CH_W:0] CH_LIMIT = (CH_W + 1)'(CHANNELS);

    logic [CHANNELS-1:0] synced_q, synced_d;
    logic [SEQ_W-1:0]    expected_q [CHANNELS];
    logic [SEQ_W-1:0]    expected_d [CHANNELS];

    logic             accept;
    logic [CH_W-1:0]  sel_ch;
    status_t          cmp_status;
    logic [SEQ_W-1:0] cmp_gap_len;
    logic [SEQ_W-1:0] cmp_next;
    logic             cmp_update;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign sel_ch   = ({1'b0, in_channel} < CH_LIMIT) ? in_channel : '0;

    stage2_seq_compare #(
        .SEQ_W(SEQ_W)
    ) u_compare (
        .synced        (synced_q[sel_ch]),
        .expected      (expected_q[sel_ch]),
        .seq           (in_seq),
        .status        (cmp_status),
        .gap_len       (cmp_gap_len),
        .next_expected (cmp_next),
        .update_en     (cmp_update)
    );

    always_comb begin
        synced_d   = synced_q;
        expected_d = expected_q;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (accept && sel_ch == CH_W'(i)) begin
                synced_d[i] = 1'b1;
                if (cmp_update) begin
                    expected_d[i] = cmp_next;
                end
            end
            // Applied after the accept so a same-cycle resync leaves the channel unsynced.
            if (resync_valid && resync_channel == CH_W'(i)) begin
                synced_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            synced_q <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                expected_q[i] <= '0;
            end
        end else begin
            synced_q   <= synced_d;
            expected_q <= expected_d;
        end
    end

    // Single output register; holds while stalled because in_ready blocks accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_channel <= '0;
            out_seq     <= '0;
            out_status  <= ST_IN_ORDER;
            out_gap_len <= '0;
            gap_events  <= '0;
        end else begin
            if (accept) begin
                out_valid   <= 1'b1;
                out_channel <= sel_ch;
                out_seq     <= in_seq;
                out_status  <= cmp_status;
                out_gap_len <= cmp_gap_len;
                if (cmp_status == ST_GAP && gap_events != '1) begin
                    gap_events <= gap_events + GAP_CNT_W'(1);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
